// File: rtl/bus_arbiter_mux_if.sv
// Shared-bus bundle between the bus controller and its sources/consumer.
// The slave modport is the controller side; master is the driving environment.
interface bus_arbiter_mux_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 8,
    parameter int unsigned SEL_W = $clog2(NSRC)
);
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  arb_en;
    logic [SEL_W-1:0]      select;
    logic [NSRC-1:0]       req;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic [NSRC-1:0]       grant;
    logic [SEL_W-1:0]      owner;

    modport master (
        output src_data, arb_en, select, req,
        input  out, out_valid, grant, owner
    );

    modport slave (
        input  src_data, arb_en, select, req,
        output out, out_valid, grant, owner
    );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered common-bus controller: drives one bus from NSRC sources either by a
// direct select index or by round-robin arbitration with a bounded hold time.
module bus_arbiter_mux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NSRC     = 8,
    parameter int unsigned SEL_W    = $clog2(NSRC),
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_mux_if.slave bus
);

    // A 1-bit counter still works for MAX_HOLD=1 (it simply stays at 0).
    localparam int unsigned     HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
    localparam logic [SEL_W-1:0]  LAST_SRC = SEL_W'(NSRC - 1);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    owner_q, owner_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic [NSRC-1:0]     grant_q, grant_d;

    logic [WIDTH-1:0]    src_arr [NSRC];
    logic [NSRC-1:0]     cand;
    logic                cand_any;
    logic [SEL_W-1:0]    cand_idx;
    logic [SEL_W-1:0]    scan_idx;
    logic                sel_ok;
    logic                owner_req;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        assign src_arr[g] = bus.src_data[g*WIDTH +: WIDTH];
    end

    // Zero-extend before comparing so non-power-of-2 NSRC can reject high indices.
    assign sel_ok    = (32'(bus.select) < NSRC);
    assign owner_req = bus.req[owner_q];

    // Round-robin scan from rr_ptr; the current owner is never its own successor.
    always_comb begin
        cand = bus.req;
        if (state_q == StOwned) begin
            cand[owner_q] = 1'b0;
        end
        cand_any = 1'b0;
        cand_idx = '0;
        scan_idx = '0;
        // Walk offsets high to low so the smallest offset from rr_ptr wins last.
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (int'(rr_ptr_q) + i >= int'(NSRC)) begin
                scan_idx = SEL_W'(int'(rr_ptr_q) + i - int'(NSRC));
            end else begin
                scan_idx = SEL_W'(int'(rr_ptr_q) + i);
            end
            if (cand[scan_idx]) begin
                cand_any = 1'b1;
                cand_idx = scan_idx;
            end
        end
    end

    // Next-state decode for both modes; all outputs follow owner_d/valid_d.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        valid_d    = valid_q;

        if (!bus.arb_en) begin
            state_d    = StIdle;
            hold_cnt_d = '0;
            valid_d    = sel_ok;
            owner_d    = sel_ok ? bus.select : '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    valid_d = 1'b0;
                    owner_d = '0;
                end
                StOwned: begin
                    if (!owner_req) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        owner_d = '0;
                    end else begin
                        valid_d = 1'b1;
                        if (hold_cnt_q != HOLD_LIM) begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    owner_d = '0;
                end
            endcase

            // New grant: from idle, on release, or on forced rotation at the hold limit.
            if (cand_any && (state_q == StIdle || !owner_req || hold_cnt_q == HOLD_LIM)) begin
                state_d    = StOwned;
                owner_d    = cand_idx;
                valid_d    = 1'b1;
                hold_cnt_d = '0;
                rr_ptr_d   = (cand_idx == LAST_SRC) ? '0 : cand_idx + 1'b1;
            end
        end

        // Data is re-sampled every cycle so a live source change shows up one cycle later.
        out_d   = valid_d ? src_arr[owner_d] : '0;
        grant_d = valid_d ? (NSRC'(1) << owner_d) : '0;
    end

    // Arbiter FSM and registered bus outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            valid_q    <= 1'b0;
            out_q      <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
            grant_q    <= grant_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.grant     = grant_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: WIDTH=8, NSRC=8, MAX_HOLD=4, src i = 8'h11*i.
module tb_bus_arbiter_mux;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned NSRC     = 8;
    localparam int unsigned MAX_HOLD = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_arbiter_mux_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();

    bus_arbiter_mux #(
        .WIDTH   (WIDTH),
        .NSRC    (NSRC),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       arb;
        logic [2:0] sel;
        logic [7:0] req;
        logic [7:0] e_out;
        logic       e_vld;
        logic [7:0] e_gnt;
        logic [2:0] e_own;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input string name, input logic rst, input logic arb,
                                input logic [2:0] sel, input logic [7:0] req,
                                input logic [7:0] e_out, input logic e_vld,
                                input logic [7:0] e_gnt, input logic [2:0] e_own);
        vec_t v;
        v.name  = name;
        v.rst   = rst;
        v.arb   = arb;
        v.sel   = sel;
        v.req   = req;
        v.e_out = e_out;
        v.e_vld = e_vld;
        v.e_gnt = e_gnt;
        v.e_own = e_own;
        return v;
    endfunction

    // Apply inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic arb, input logic [2:0] sel,
                        input logic [7:0] req);
        reset      = rst;
        bus.arb_en = arb;
        bus.select = sel;
        bus.req    = req;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] e_out, input logic e_vld,
                         input logic [7:0] e_gnt, input logic [2:0] e_own);
        n_tests++;
        if (bus.out !== e_out || bus.out_valid !== e_vld || bus.grant !== e_gnt ||
            bus.owner !== e_own) begin
            n_fail++;
            $display("FAIL %s: got out=%h valid=%b grant=%h owner=%0d, want out=%h valid=%b grant=%h owner=%0d",
                     name, bus.out, bus.out_valid, bus.grant, bus.owner,
                     e_out, e_vld, e_gnt, e_own);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NSRC); i++) begin
            bus.src_data[i*8 +: 8] = 8'(17 * i);
        end
        reset      = 1'b1;
        bus.arb_en = 1'b0;
        bus.select = '0;
        bus.req    = '0;

        // Reset with arbitrary inputs.
        vecs.push_back(mk("rst_a",     1, 1, 3'd3, 8'hff, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk("rst_b",     1, 0, 3'd5, 8'h00, 8'h00, 0, 8'h00, 0));
        // Direct mode.
        vecs.push_back(mk("dir_sel0",  0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h01, 0));
        vecs.push_back(mk("dir_sel1",  0, 0, 3'd1, 8'h00, 8'h11, 1, 8'h02, 1));
        vecs.push_back(mk("dir_sel7",  0, 0, 3'd7, 8'h00, 8'h77, 1, 8'h80, 7));
        // Round-robin, each winner drops its request after being granted.
        vecs.push_back(mk("rr_own0",   0, 1, 3'd0, 8'h85, 8'h00, 1, 8'h01, 0));
        vecs.push_back(mk("rr_own2",   0, 1, 3'd0, 8'h84, 8'h22, 1, 8'h04, 2));
        vecs.push_back(mk("rr_own7",   0, 1, 3'd0, 8'h80, 8'h77, 1, 8'h80, 7));
        vecs.push_back(mk("rr_idle",   0, 1, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk("rr_wrap0",  0, 1, 3'd0, 8'h01, 8'h00, 1, 8'h01, 0));
        vecs.push_back(mk("rr_idle2",  0, 1, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        // Lock limit with two contenders: 4 cycles each.
        vecs.push_back(mk("lock1_c0",  0, 1, 3'd0, 8'h06, 8'h11, 1, 8'h02, 1));
        vecs.push_back(mk("lock1_c1",  0, 1, 3'd0, 8'h06, 8'h11, 1, 8'h02, 1));
        vecs.push_back(mk("lock1_c2",  0, 1, 3'd0, 8'h06, 8'h11, 1, 8'h02, 1));
        vecs.push_back(mk("lock1_c3",  0, 1, 3'd0, 8'h06, 8'h11, 1, 8'h02, 1));
        vecs.push_back(mk("lock2_c0",  0, 1, 3'd0, 8'h06, 8'h22, 1, 8'h04, 2));
        vecs.push_back(mk("lock2_c1",  0, 1, 3'd0, 8'h06, 8'h22, 1, 8'h04, 2));
        vecs.push_back(mk("lock2_c2",  0, 1, 3'd0, 8'h06, 8'h22, 1, 8'h04, 2));
        vecs.push_back(mk("lock2_c3",  0, 1, 3'd0, 8'h06, 8'h22, 1, 8'h04, 2));
        vecs.push_back(mk("lock_back", 0, 1, 3'd0, 8'h06, 8'h11, 1, 8'h02, 1));
        vecs.push_back(mk("lock_rel",  0, 1, 3'd0, 8'h00, 8'h00, 0, 8'h00, 0));
        vecs.push_back(mk("sole_gnt3", 0, 1, 3'd0, 8'h08, 8'h33, 1, 8'h08, 3));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].arb, vecs[i].sel, vecs[i].req);
            check(vecs[i].name, vecs[i].e_out, vecs[i].e_vld, vecs[i].e_gnt, vecs[i].e_own);
        end

        // Sole requester keeps the bus well past the hold limit.
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 3'd0, 8'h08);
            check("sole_hold", 8'h33, 1, 8'h08, 3);
        end

        // Reset during an active grant, then the bus is free right after release.
        step(1, 1, 3'd0, 8'h08);
        check("rst_mid", 8'h00, 0, 8'h00, 0);
        step(0, 1, 3'd0, 8'h08);
        check("post_rst_gnt", 8'h33, 1, 8'h08, 3);

        // Live data: owner 5 sees a source change one cycle later.
        step(0, 1, 3'd0, 8'h20);
        check("live_own5", 8'h55, 1, 8'h20, 5);
        bus.src_data[5*8 +: 8] = 8'hA5;
        step(0, 1, 3'd0, 8'h20);
        check("live_a5", 8'hA5, 1, 8'h20, 5);
        bus.src_data[5*8 +: 8] = 8'h55;
        step(0, 1, 3'd0, 8'h20);
        check("live_55", 8'h55, 1, 8'h20, 5);

        // Mode switch out of and back into arbitrated mode.
        step(0, 1, 3'd0, 8'h10);
        check("ms_own4", 8'h44, 1, 8'h10, 4);
        step(0, 0, 3'd6, 8'h10);
        check("ms_direct6", 8'h66, 1, 8'h40, 6);
        step(0, 1, 3'd0, 8'h10);
        check("ms_back4", 8'h44, 1, 8'h10, 4);
        // Hold count restarted: owner 4 keeps 3 more cycles, then rotates to 0.
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 3'd0, 8'h11);
            check("ms_hold4", 8'h44, 1, 8'h10, 4);
        end
        step(0, 1, 3'd0, 8'h11);
        check("ms_rot0", 8'h00, 1, 8'h01, 0);

        // Release coinciding with the hold limit behaves as a plain release.
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 3'd0, 8'h11);
        end
        step(0, 1, 3'd0, 8'h30);
        check("rel_at_lim", 8'h44, 1, 8'h10, 4);

        // Out-of-range direct select is impossible with NSRC=8; check direct idle via req only.
        step(0, 0, 3'd2, 8'h00);
        check("dir_sel2", 8'h22, 1, 8'h04, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered common-bus controller for the RISC CPU datapath. It replaces the fixed 8-source, 8-bit combinational bus selector. It drives one shared bus from NSRC sources of WIDTH bits and supports two modes:
- Direct mode: a control-unit select index chooses the source, as today.
- Arbitrated mode: a round-robin request/grant scheme with a bounded bus lock, used by multi-master extensions (memory, DMA, I/O).

## Interface
Parameters:
- WIDTH, 8, bus and source data width in bits
- NSRC, 8, number of sources (≥2)
- SEL_W, $clog2(NSRC), width of select/owner index
- MAX_HOLD, 4, max consecutive cycles one owner keeps the bus while another source requests (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- src_data  in  NSRC*WIDTH  flattened sources; source i at [i*WIDTH +: WIDTH]
- arb_en  in  1  0 = direct mode, 1 = arbitrated mode
- select  in  SEL_W  direct-mode source index
- req  in  NSRC  arbitrated-mode request per source
- out  out  WIDTH  registered bus value
- out_valid  out  1  out carries a legally selected/granted source
- grant  out  NSRC  registered one-hot owner indication (all zero when none)
- owner  out  SEL_W  index of current driver (0 when none)

## Operation
- Internal state: arbiter FSM {IDLE, OWNED}, rr_ptr (SEL_W), hold_cnt (sized for MAX_HOLD).
- Direct mode (arb_en=0), every cycle:
  - If select < NSRC: out←src_data[select], out_valid←1, owner←select, grant←one-hot(select).
  - If select ≥ NSRC (non-power-of-2 NSRC): out←0, out_valid←0, owner←0, grant←0.
  - FSM forced to IDLE and hold_cnt←0. rr_ptr is unchanged.
- Arbitrated mode (arb_en=1):
  - IDLE, no req: out←0, out_valid←0, grant←0, owner←0.
  - IDLE, any req: pick the first set req scanning upward from rr_ptr, wrapping at NSRC. Go to OWNED with that owner, set hold_cnt←0 and rr_ptr←(winner+1) mod NSRC.
  - OWNED: out←src_data[owner] every cycle (live, not latched at grant). out_valid←1.
  - Release: req[owner]=0 sampled. Re-arbitrate in the same cycle among the remaining reqs, scanning from rr_ptr. If any remain, the new owner is granted on the next edge with no idle gap. Otherwise go to IDLE.
  - Lock: while req[owner]=1, hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - Forced rotation: if hold_cnt=MAX_HOLD-1, req[owner]=1 and any other req is set, grant the next other requester from rr_ptr. The current owner is excluded from this scan.
  - Sole requester: if no other req is set, the owner keeps the bus indefinitely.
  - Every new grant resets hold_cnt←0 and sets rr_ptr←(new owner+1) mod NSRC.
- Mode switch: arb_en is sampled each edge. The change takes effect on that edge's outputs. Entering arbitrated mode starts from IDLE.

## Timing
- Reset values: out=0, out_valid=0, grant=0, owner=0. Internal: rr_ptr=0, hold_cnt=0, FSM=IDLE.
- Reset has priority over all inputs, including mid-ownership. The bus is free the cycle after reset deasserts.
- Latency is one cycle: inputs sampled at edge k appear on out/grant/owner after edge k.
- Source data change while owned appears on out one cycle later.
- grant is always one-hot or zero. owner and grant always agree. out_valid=|grant.
- Handover: owner drops req at edge k → new grant and new out after edge k; old owner's grant is low after edge k.
- Simultaneous release and forced-rotation condition: treat as release; the scan includes all other reqs.
- rr_ptr wraps from NSRC-1 to 0.

## Test plan
Use WIDTH=8, NSRC=8, MAX_HOLD=4, with src i = 8'h11*i.
- Reset: assert reset 2 cycles with arbitrary inputs → out=0, out_valid=0, grant=0, owner=0. Hold reset during an active grant → grant=0 next cycle.
- Direct mode: arb_en=0, select=0, 1, 7 on consecutive cycles → out=8'h00, 8'h11, 8'h77 one cycle later; grant=8'h01, 8'h02, 8'h80.
- Round-robin: arb_en=1, req=8'b1000_0101 held, each winner dropping req one cycle after grant → owners 0, 2, 7. Then with req=8'h01 again → owner 0 (wrap).
- Lock limit: req=8'h06 continuously → owner 1 for 4 cycles, then owner 2 for 4 cycles, then owner 1. Only req[3] set → owner 3 holds for ≥10 cycles.
- Live data: owner 5, change src5 from 8'h55 to 8'hA5 → out=8'hA5 one cycle later, grant unchanged.
- Mode switch: while owner 4 is granted in arbitrated mode, set arb_en=0, select=6 → next cycle out=8'h66, grant=8'h40. Return to arb_en=1 with req=8'h10 → grant=8'h10, hold_cnt restarts.
